// File: rtl/axi_sram_pkg.sv
// Shared FSM encoding, AXI burst/response constants and beat-size helpers
// for the AXI SRAM responder.
package axi_sram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRdData,
        StWrData,
        StWrResp
    } state_e;

    // Records which channel won the most recent grant; the other one wins the next tie.
    typedef enum logic {
        ChWrite = 1'b0,
        ChRead  = 1'b1
    } chan_e;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bytes per beat; sizes above one word are clamped to one word.
    function automatic logic [2:0] beat_incr(input logic [2:0] size);
        case (size)
            3'd0:    return 3'd1;
            3'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // WRAP and the reserved encoding step through memory like INCR.
    function automatic logic burst_advances(input logic [1:0] burst);
        case (burst)
            BURST_FIXED:            return 1'b0;
            BURST_INCR, BURST_WRAP: return 1'b1;
            default:                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// Single-ID 32-bit AXI channel bundle between the CPU-side bridge (master)
// and the SRAM responder (slave).
interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Burst address/beat tracker shared by the read and write paths: latches the
// request on load and advances the byte address and beat counter on step.
module axi_burst_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [31:0]       i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_word_addr,
    output logic              o_last
);

    localparam int unsigned BYTE_AW = ADDR_W + 2;

    // Only the bits that reach the SRAM are kept, so bursts wrap modulo the memory size.
    logic [BYTE_AW-1:0] r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic [2:0]         r_incr;
    logic               r_advance;
    logic               w_unused_addr;

    assign w_unused_addr = ^i_addr[31:BYTE_AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_incr    <= '0;
            r_advance <= 1'b0;
        end else if (i_load) begin
            r_addr    <= i_addr[BYTE_AW-1:0];
            r_len     <= i_len;
            r_cnt     <= '0;
            r_incr    <= beat_incr(i_size);
            r_advance <= burst_advances(i_burst);
        end else if (i_step) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_advance) begin
                r_addr <= r_addr + BYTE_AW'(r_incr);
            end
        end
    end

    assign o_word_addr = r_addr[BYTE_AW-1:2];
    assign o_last      = (r_cnt == r_len);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI responder backed by a 1-cycle-latency single-port SRAM; serves one read
// or write burst at a time with alternating priority on simultaneous requests.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    axi_sram_slave_if.slave   axi,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e            r_state;
    state_e            w_state_next;
    chan_e             r_last_grant;
    logic [3:0]        r_id;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_ar_grant;
    logic              w_aw_grant;
    logic              w_w_hs;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_ar_grant = (r_state == StIdle) && axi.arvalid &&
                        (!axi.awvalid || r_last_grant == ChWrite);
    assign w_aw_grant = (r_state == StIdle) && axi.awvalid &&
                        (!axi.arvalid || r_last_grant == ChRead);

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ar_grant || w_aw_grant),
        .i_addr      (w_ar_grant ? axi.araddr  : axi.awaddr),
        .i_len       (w_ar_grant ? axi.arlen   : axi.awlen),
        .i_size      (w_ar_grant ? axi.arsize  : axi.awsize),
        .i_burst     (w_ar_grant ? axi.arburst : axi.awburst),
        .i_step      (w_step),
        .o_word_addr (w_word_addr),
        .o_last      (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        w_w_hs       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_ar_grant) begin
                    w_state_next = StRdReq;
                end else if (w_aw_grant) begin
                    w_state_next = StWrData;
                end
            end
            StRdReq:  w_state_next = StRdWait;
            StRdWait: w_state_next = StRdData;
            StRdData: begin
                if (axi.rready) begin
                    if (w_last) begin
                        w_state_next = StIdle;
                    end else begin
                        w_step       = 1'b1;
                        w_state_next = StRdReq;
                    end
                end
            end
            StWrData: begin
                if (axi.wvalid) begin
                    w_w_hs = 1'b1;
                    if (w_last) begin
                        w_state_next = StWrResp;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            StWrResp: begin
                if (axi.bready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_grant <= ChWrite;
            r_id         <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ar_grant) begin
                r_last_grant <= ChRead;
                r_id         <= axi.arid;
            end else if (w_aw_grant) begin
                r_last_grant <= ChWrite;
                r_id         <= axi.awid;
                r_err        <= 1'b0;
            end
            if (r_state == StRdWait) begin
                r_rdata <= ram_rdata;
            end
            // wlast must line up exactly with the final beat; any mismatch poisons the burst.
            if (w_w_hs && (axi.wlast != w_last)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        axi.arready = w_ar_grant;
        axi.awready = w_aw_grant;
        axi.wready  = (r_state == StWrData);
        axi.rvalid  = (r_state == StRdData);
        axi.rlast   = (r_state == StRdData) && w_last;
        axi.rdata   = r_rdata;
        axi.rid     = r_id;
        axi.rresp   = RESP_OKAY;
        axi.bvalid  = (r_state == StWrResp);
        axi.bid     = r_id;
        axi.bresp   = r_err ? RESP_SLVERR : RESP_OKAY;
        ram_en      = (r_state == StRdReq) || w_w_hs;
        ram_wen     = w_w_hs ? axi.wstrb : 4'h0;
        ram_addr    = w_word_addr;
        ram_wdata   = w_w_hs ? axi.wdata : 32'h0;
    end

endmodule
